// File: rtl/afir_pkg.sv
// afir_pkg: shared types and width helpers for the adaptive FIR.
// Accumulator, shift and clamp sizes derive from DW/WW/TAPS.
package afir_pkg;

    typedef enum logic {IDLE, RUN} fsm_e;

    function automatic int acc_w(int dw, int taps);
        return 2 * dw + $clog2(taps) + 1;
    endfunction

    function automatic int prod_sh(int dw, int ww);
        return 2 * dw - 1 - ww;
    endfunction

    function automatic longint sat_hi(int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(int n);
        return -sat_hi(n) - 64'sd1;
    endfunction

endpackage

// File: rtl/afir_chan_mem.sv
// afir_chan_mem: per-channel delay lines and weight banks.
// Shift port, x/w read ports, one w write port, bulk clear.
module afir_chan_mem #(
    parameter int DW   = 16,
    parameter int WW   = 24,
    parameter int TAPS = 64,
    parameter int CH   = 4,
    parameter int CHW  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sh_en_i,
    input  logic [CHW-1:0]             sh_ch_i,
    input  logic signed [DW-1:0]       sh_x_i,
    input  logic [CHW-1:0]             rd_ch_i,
    input  logic [$clog2(TAPS)-1:0]    xr_idx_i,
    output logic signed [DW-1:0]       x_o,
    input  logic [$clog2(TAPS)-1:0]    wr_idx_i,
    output logic signed [WW-1:0]       w_o,
    input  logic                       we_i,
    input  logic [$clog2(TAPS)-1:0]    we_idx_i,
    input  logic signed [WW-1:0]       we_d_i,
    input  logic                       clr_i,
    input  logic [CHW-1:0]             clr_ch_i
);
    logic signed [DW-1:0] x_q [CH][TAPS];
    logic signed [WW-1:0] w_q [CH][TAPS];

    assign x_o = x_q[rd_ch_i][xr_idx_i];
    assign w_o = w_q[rd_ch_i][wr_idx_i];

    // delay lines: clear wins, otherwise shift the new sample in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++)
                for (int t = 0; t < TAPS; t++)
                    x_q[c][t] <= '0;
        end else if (clr_i) begin
            for (int t = 0; t < TAPS; t++)
                x_q[clr_ch_i][t] <= '0;
        end else if (sh_en_i) begin
            x_q[sh_ch_i][0] <= sh_x_i;
            for (int t = 1; t < TAPS; t++)
                x_q[sh_ch_i][t] <= x_q[sh_ch_i][t-1];
        end
    end

    // weight banks: clear in idle, adapted writes during a run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++)
                for (int t = 0; t < TAPS; t++)
                    w_q[c][t] <= '0;
        end else if (clr_i) begin
            for (int t = 0; t < TAPS; t++)
                w_q[clr_ch_i][t] <= '0;
        end else if (we_i) begin
            w_q[rd_ch_i][we_idx_i] <= we_d_i;
        end
    end
endmodule

// File: rtl/bw_mult.sv
// bw_mult: full-width signed multiplier, product is 2*W bits.
// Purely combinational; the caller registers the result.
module bw_mult #(
    parameter int W = 16
) (
    input  logic signed [W-1:0]   a_i,
    input  logic signed [W-1:0]   b_i,
    output logic signed [2*W-1:0] p_o
);
    assign p_o = (2 * W)'(a_i) * (2 * W)'(b_i);
endmodule

// File: rtl/saturate.sv
// saturate: symmetric signed clamp from IW bits down to OW bits.
// Values outside [-2^(OW-1), 2^(OW-1)-1] pin to the nearest bound.
module saturate
    import afir_pkg::*;
#(
    parameter int IW = 25,
    parameter int OW = 24
) (
    input  logic signed [IW-1:0] d_i,
    output logic signed [OW-1:0] q_o
);
    localparam logic signed [IW-1:0] HI = IW'(sat_hi(OW));
    localparam logic signed [IW-1:0] LO = IW'(sat_lo(OW));

    // clamp to the representable output range
    always_comb begin
        if (d_i > HI)      q_o = HI[OW-1:0];
        else if (d_i < LO) q_o = LO[OW-1:0];
        else               q_o = d_i[OW-1:0];
    end
endmodule

// File: rtl/adaptive_fir_mc.sv
// adaptive_fir_mc: multi-channel LMS FIR on one shared MAC pipe.
// Per sample: adapt each weight, then accumulate with the new weight.
module adaptive_fir_mc
    import afir_pkg::*;
#(
    parameter int DW   = 16,
    parameter int WW   = 24,
    parameter int TAPS = 64,
    parameter int CH   = 4,
    parameter int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic [DW-1:0]  x_in,
    input  logic [DW-1:0]  a_in,
    input  logic [DW-1:0]  mu_err,
    input  logic           adapt_en,
    input  logic           clr_valid,
    input  logic [CHW-1:0] clr_ch,
    output logic           out_valid,
    output logic [CHW-1:0] out_ch,
    output logic [DW-1:0]  out_sample,
    output logic           busy,
    output logic           err_ch
);
    localparam int KW = $clog2(TAPS);
    localparam int AW = acc_w(DW, TAPS);
    localparam int SH = prod_sh(DW, WW);
    localparam logic [CHW:0] CH_LIM = (CHW + 1)'(CH);

    fsm_e                 state_q;
    logic                 rdy_q, aen_q, err_q, ov_q;
    logic [CHW-1:0]       ch_q, och_q;
    logic signed [DW-1:0] mu_q;
    logic [DW-1:0]        osmp_q;
    logic [KW:0]          cnt_q;
    logic [4:0]           vp_q;
    logic signed [AW-1:0] acc_q;

    logic signed [DW-1:0]   x1_q, x2_q, x3_q, x4_q, c3_q, c4_q;
    logic [KW-1:0]          k1_q, k2_q;
    logic signed [2*DW-1:0] prod2_q, mp5_q, prod1, mprod;

    logic signed [DW-1:0] x_rd, c3_d, osat;
    logic signed [WW-1:0] w_rd, wsat;
    logic signed [WW:0]   wsum, padd;
    logic signed [AW-1:0] acc_sh, mp_ext, acc_init;
    logic idle, in_ok, clr_ok, acc_go, clr_go, iss, fin, err_d;

    assign idle     = state_q == IDLE;
    assign in_ok    = {1'b0, in_ch} < CH_LIM;
    assign clr_ok   = {1'b0, clr_ch} < CH_LIM;
    assign in_ready = rdy_q & idle & ~clr_valid;
    assign acc_go   = in_valid & in_ready & in_ok;
    assign clr_go   = clr_valid & rdy_q & idle & clr_ok;
    assign err_d    = (in_valid & in_ready & ~in_ok)
                    | (clr_valid & rdy_q & idle & ~clr_ok);
    assign iss      = ~idle & ~cnt_q[KW];
    assign fin      = ~idle & cnt_q[KW] & (vp_q == '0);

    assign padd     = (WW + 1)'(prod2_q >>> SH);
    assign wsum     = {w_rd[WW-1], w_rd} + padd;
    assign c3_d     = aen_q ? wsat[WW-1 -: DW] : w_rd[WW-1 -: DW];
    assign mp_ext   = {{(AW-2*DW){mp5_q[2*DW-1]}}, mp5_q};
    assign acc_init = {{(AW-DW){a_in[DW-1]}}, a_in} << (DW - 1);
    assign acc_sh   = acc_q >>> (DW - 1);

    assign out_valid  = ov_q;
    assign out_ch     = och_q;
    assign out_sample = osmp_q;
    assign busy       = ~idle;
    assign err_ch     = err_q;

    afir_chan_mem #(
        .DW(DW), .WW(WW), .TAPS(TAPS), .CH(CH), .CHW(CHW)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .sh_en_i  (acc_go),
        .sh_ch_i  (in_ch),
        .sh_x_i   (x_in),
        .rd_ch_i  (ch_q),
        .xr_idx_i (cnt_q[KW-1:0]),
        .x_o      (x_rd),
        .wr_idx_i (k2_q),
        .w_o      (w_rd),
        .we_i     (vp_q[1] & aen_q),
        .we_idx_i (k2_q),
        .we_d_i   (wsat),
        .clr_i    (clr_go),
        .clr_ch_i (clr_ch)
    );

    bw_mult #(.W(DW)) u_mul_w (.a_i(mu_q), .b_i(x1_q), .p_o(prod1));
    bw_mult #(.W(DW)) u_mul_o (.a_i(c4_q), .b_i(x4_q), .p_o(mprod));

    saturate #(.IW(WW + 1), .OW(WW)) u_sat_w (.d_i(wsum), .q_o(wsat));
    saturate #(.IW(AW), .OW(DW)) u_sat_o (.d_i(acc_sh), .q_o(osat));

    // tap pipe: read x, update product, adapt, coef, mult product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vp_q    <= '0;
            x1_q    <= '0;
            k1_q    <= '0;
            prod2_q <= '0;
            x2_q    <= '0;
            k2_q    <= '0;
            c3_q    <= '0;
            x3_q    <= '0;
            c4_q    <= '0;
            x4_q    <= '0;
            mp5_q   <= '0;
        end else begin
            vp_q    <= {vp_q[3:0], iss};
            x1_q    <= x_rd;
            k1_q    <= cnt_q[KW-1:0];
            prod2_q <= prod1;
            x2_q    <= x1_q;
            k2_q    <= k1_q;
            c3_q    <= c3_d;
            x3_q    <= x2_q;
            c4_q    <= c3_q;
            x4_q    <= x3_q;
            mp5_q   <= mprod;
        end
    end

    // control FSM: accept, issue taps, accumulate, emit result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            ch_q    <= '0;
            mu_q    <= '0;
            aen_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ov_q    <= 1'b0;
            och_q   <= '0;
            osmp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            ov_q  <= 1'b0;
            err_q <= err_d;
            unique case (state_q)
                IDLE: begin
                    if (acc_go) begin
                        state_q <= RUN;
                        ch_q    <= in_ch;
                        mu_q    <= mu_err;
                        aen_q   <= adapt_en;
                        cnt_q   <= '0;
                        acc_q   <= acc_init;
                    end
                end
                RUN: begin
                    if (iss) cnt_q <= cnt_q + 1'b1;
                    if (vp_q[4]) acc_q <= acc_q + mp_ext;
                    if (fin) begin
                        state_q <= IDLE;
                        ov_q    <= 1'b1;
                        och_q   <= ch_q;
                        osmp_q  <= osat;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adaptive_fir_mc.sv
// tb_adaptive_fir_mc: directed checks of the adaptive FIR.
// Main DUT has CH=4, TAPS=4; a CH=3 copy covers invalid ids.
module tb_adaptive_fir_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, clr_valid = 1'b0, adapt_en = 1'b0;
    logic        in_valid3 = 1'b0, clr_valid3 = 1'b0;
    logic [1:0]  in_ch = '0, clr_ch = '0;
    logic [15:0] x_in = '0, a_in = '0, mu_err = '0;

    logic        in_ready, out_valid, busy, err_ch;
    logic [1:0]  out_ch;
    logic [15:0] out_sample;
    logic        in_ready3, out_valid3, busy3, err_ch3;
    logic [1:0]  out_ch3;
    logic [15:0] out_sample3;

    int errors = 0;
    int checks = 0;
    logic seen;

    always #5 clk = ~clk;

    adaptive_fir_mc #(.DW(16), .WW(24), .TAPS(4), .CH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .x_in(x_in), .a_in(a_in), .mu_err(mu_err),
        .adapt_en(adapt_en), .clr_valid(clr_valid), .clr_ch(clr_ch),
        .out_valid(out_valid), .out_ch(out_ch), .out_sample(out_sample),
        .busy(busy), .err_ch(err_ch)
    );

    adaptive_fir_mc #(.DW(16), .WW(24), .TAPS(4), .CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_ch(in_ch), .x_in(x_in), .a_in(a_in), .mu_err(mu_err),
        .adapt_en(adapt_en), .clr_valid(clr_valid3), .clr_ch(clr_ch),
        .out_valid(out_valid3), .out_ch(out_ch3), .out_sample(out_sample3),
        .busy(busy3), .err_ch(err_ch3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] ch, input logic [15:0] x,
                         input logic [15:0] a, input logic [15:0] mu,
                         input logic en);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("start.ready", 32'(n < 40), 1);
        in_ch = ch; x_in = x; a_in = a; mu_err = mu; adapt_en = en;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] ch,
                       input logic [15:0] x, input logic [15:0] a,
                       input logic [15:0] mu, input logic en,
                       input logic [15:0] exp);
        int lat;
        logic rdy_hi;
        logic [15:0] s;
        logic [1:0] c;
        start(ch, x, a, mu, en);
        lat = 0; rdy_hi = 1'b0; s = '0; c = '0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n; s = out_sample; c = out_ch;
                break;
            end
            if (in_ready) rdy_hi = 1'b1;
        end
        chk({tag, ".latency"}, lat, 10);
        chk({tag, ".out"}, {16'h0, s}, {16'h0, exp});
        chk({tag, ".ch"}, {30'h0, c}, {30'h0, ch});
        chk({tag, ".ready_low"}, {31'h0, rdy_hi}, 0);
    endtask

    task automatic clear(input logic [1:0] ch);
        @(negedge clk);
        clr_ch = ch; clr_valid = 1'b1;
        @(posedge clk);
        #1 clr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst.in_ready", {31'h0, in_ready}, 0);
        chk("rst.out_valid", {31'h0, out_valid}, 0);
        chk("rst.busy", {31'h0, busy}, 0);
        chk("rst.out_sample", {16'h0, out_sample}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.ready_after", {31'h0, in_ready}, 1);

        run("s1", 2'd0, 16'h4000, 16'h0, 16'h4000, 1'b1, 16'h1000);
        chk("s1.w00", {8'h0, dut.u_mem.w_q[0][0]}, 32'h200000);
        run("s2", 2'd0, 16'h4000, 16'h0, 16'h4000, 1'b0, 16'h1000);
        chk("s2.w00", {8'h0, dut.u_mem.w_q[0][0]}, 32'h200000);
        chk("s2.w01", {8'h0, dut.u_mem.w_q[0][1]}, 32'h0);
        run("s3", 2'd2, 16'h4000, 16'h0, 16'h4000, 1'b1, 16'h1000);
        chk("s3.w20", {8'h0, dut.u_mem.w_q[2][0]}, 32'h200000);
        chk("s3.w00", {8'h0, dut.u_mem.w_q[0][0]}, 32'h200000);

        @(negedge clk);
        clr_ch = 2'd0; clr_valid = 1'b1;
        in_ch = 2'd0; x_in = 16'h1234; in_valid = 1'b1;
        #1 chk("clr.in_ready", {31'h0, in_ready}, 0);
        @(posedge clk); #1;
        clr_valid = 1'b0; in_valid = 1'b0;
        chk("clr.busy", {31'h0, busy}, 0);
        chk("clr.w00", {8'h0, dut.u_mem.w_q[0][0]}, 32'h0);
        chk("clr.x00", {16'h0, dut.u_mem.x_q[0][0]}, 32'h0);
        chk("clr.w20", {8'h0, dut.u_mem.w_q[2][0]}, 32'h200000);
        chk("clr.x20", {16'h0, dut.u_mem.x_q[2][0]}, 32'h4000);
        run("s4", 2'd0, 16'h4000, 16'h0, 16'h4000, 1'b1, 16'h1000);
        chk("s4.w00", {8'h0, dut.u_mem.w_q[0][0]}, 32'h200000);

        run("sat_pos", 2'd1, 16'h4000, 16'h7FFF, 16'h4000, 1'b1, 16'h7FFF);
        run("sat_neg", 2'd3, 16'h4000, 16'h8000, 16'hC000, 1'b1, 16'h8000);
        chk("sat_neg.w30", {8'h0, dut.u_mem.w_q[3][0]}, 32'hE00000);

        clear(2'd1);
        run("wsat1", 2'd1, 16'h7FFF, 16'h0, 16'h7FFF, 1'b1, 16'h7FFD);
        chk("wsat1.w10", {8'h0, dut.u_mem.w_q[1][0]}, 32'h7FFE00);
        run("wsat2", 2'd1, 16'h7FFF, 16'h0, 16'h7FFF, 1'b1, 16'h7FFF);
        chk("wsat2.w10", {8'h0, dut.u_mem.w_q[1][0]}, 32'h7FFFFF);
        chk("wsat2.w11", {8'h0, dut.u_mem.w_q[1][1]}, 32'h7FFE00);
        run("wsat3", 2'd1, 16'h7FFF, 16'h0, 16'h7FFF, 1'b1, 16'h7FFF);
        chk("wsat3.w10", {8'h0, dut.u_mem.w_q[1][0]}, 32'h7FFFFF);
        chk("wsat3.w11", {8'h0, dut.u_mem.w_q[1][1]}, 32'h7FFFFF);

        start(2'd3, 16'h4000, 16'h0, 16'h4000, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        chk("abort.busy_pre", {31'h0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", {31'h0, out_valid}, 0);
        chk("abort.busy", {31'h0, busy}, 0);
        chk("abort.in_ready", {31'h0, in_ready}, 0);
        chk("abort.out_sample", {16'h0, out_sample}, 0);
        chk("abort.out_ch", {30'h0, out_ch}, 0);
        chk("abort.w00", {8'h0, dut.u_mem.w_q[0][0]}, 32'h0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort.no_out", {31'h0, seen}, 0);
        run("post", 2'd0, 16'h4000, 16'h0, 16'h4000, 1'b1, 16'h1000);

        @(negedge clk);
        in_ch = 2'd3; in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        chk("bad_in.err", {31'h0, err_ch3}, 1);
        chk("bad_in.busy", {31'h0, busy3}, 0);
        @(posedge clk); #1;
        chk("bad_in.pulse", {31'h0, err_ch3}, 0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid3 || busy3) seen = 1'b1;
        end
        chk("bad_in.no_run", {31'h0, seen}, 0);

        @(negedge clk);
        clr_ch = 2'd3; clr_valid3 = 1'b1;
        @(posedge clk); #1;
        clr_valid3 = 1'b0;
        chk("bad_clr.err", {31'h0, err_ch3}, 1);

        @(negedge clk);
        clr_ch = 2'd0; clr_valid3 = 1'b1;
        in_ch = 2'd0; in_valid3 = 1'b1;
        #1 chk("clr_in.ready", {31'h0, in_ready3}, 0);
        @(posedge clk); #1;
        clr_valid3 = 1'b0; in_valid3 = 1'b0;
        chk("clr_in.busy", {31'h0, busy3}, 0);
        chk("clr_in.err", {31'h0, err_ch3}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adaptive_fir_mc.md
Name: adaptive_fir_mc

Overview:
- Multi-channel, parametrised LMS-style adaptive FIR. One MAC pipeline is time-shared across CH independent channels.
- Each channel owns its own delay line and weight bank.
- Per accepted sample the block runs two passes over the channel's taps:
  - weight update: w += mu_err * x, saturated;
  - output accumulation: out = a_in + sum(coef * x), using the updated weights.
- Sits between the sample controller and the output mixer. Adds per-sample freeze (adapt_en), per-channel clear, and channel-id error reporting.

Parameters:
- DW, 16: sample/coef width, Q1.(DW-1).
- WW, 24: weight register width, Q1.(WW-1). Legal range DW <= WW <= 2*DW-1.
- TAPS, 64: taps per channel, power of 2, >= 4.
- CH, 4: channel count, >= 1.
- CHW, max(1,$clog2(CH)): channel id width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  sample request
- in_ready  out  1  high only in IDLE with clr_valid low
- in_ch  in  CHW  target channel
- x_in  in  DW  new sample, signed
- a_in  in  DW  additive offset, signed
- mu_err  in  DW  step*error, signed
- adapt_en  in  1  1 = update weights this sample, 0 = freeze
- clr_valid  in  1  clear command
- clr_ch  in  CHW  channel to clear
- out_valid  out  1  one-cycle result strobe
- out_ch  out  CHW  channel of result
- out_sample  out  DW  saturated result
- busy  out  1  high in RUN
- err_ch  out  1  one-cycle pulse when an id >= CH is presented

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: all x/w storage 0, all outputs 0 (in_ready 0 during reset, 1 the first cycle after), FSM in IDLE. Reset mid-RUN aborts with no out_valid.
- FSM:
  - IDLE -> RUN on in_valid & in_ready & in_ch < CH.
  - RUN -> IDLE after the last accumulate.
- Accept cycle (edge 0):
  - latch ch, a_in, mu_err, adapt_en;
  - shift channel delay line, x[ch][0] <= x_in;
  - acc <= sign-extended a_in <<< (DW-1).
- RUN, tap index k = 0..TAPS-1 issued one per cycle through a 6-stage pipe:
  1. read x[k];
  2. prod = mu_err * x[k], 2*DW bits;
  3. if adapt_en: w[k] <= sat_WW(w[k] + (prod >>> (2*DW-1-WW))), with sum width WW+1;
  4. read coef = w[k][WW-1 -: DW], truncated (uses the stage-3 result);
  5. mprod = coef * x[k];
  6. acc += mprod.
- Accumulator width 2*DW + log2(TAPS) + 1.
- Completion: out_valid rises exactly TAPS+6 cycles after the accept edge.
  - out_sample = sat_DW(acc >>> (DW-1)), out_ch = ch.
  - FSM returns to IDLE the same cycle; in_ready is high the next cycle.
- adapt_en=0: weights bit-for-bit unchanged; output still computed.
- Clear:
  - accepted in IDLE only; zeroes x and w of clr_ch in one cycle;
  - has priority over in_valid in the same cycle (in_ready low that cycle, sample not taken).
  - clr_valid during RUN is ignored.
- Invalid id (in_ch or clr_ch >= CH, only possible when CH is not a power of 2): command dropped, err_ch pulses one cycle, state and storage untouched.
- in_valid during RUN: in_ready=0, nothing taken.
- Saturation: symmetric clamp to [-2^(n-1), 2^(n-1)-1], applied to the weight sum and to the output only.

Decomposition:
- Package afir_pkg:
  - width helper functions (acc width, shift amount);
  - FSM state enum {IDLE, RUN};
  - sat-bound constants.
- Reuse the existing bw_mult for both multipliers and the existing saturate for both clamps.
- One natural sub-module: afir_chan_mem. It holds the per-channel x/w banks with a shift port, one read port each for x and w at separate stage indices, one w write port, and a bulk-clear port.

Test Plan (DW=16, WW=24, TAPS=4, CH=4 unless noted):
- Reset, then ch0 with x=0x4000, mu_err=0x4000, a_in=0, adapt_en=1 -> w0 = 0.25, out_sample=0x1000, out_ch=0, out_valid exactly 10 cycles after accept, in_ready 0 throughout.
- Repeat the same ch0 sample with adapt_en=0 -> weights unchanged. Delay line is [0x4000, 0x4000, 0, 0] and w1=0, so out_sample=0x1000 again.
- Same stimulus on ch2 after ch0 has trained -> ch2 out_sample=0x1000, ch0 weights unaffected (channel isolation). clr_valid ch0 -> next ch0 sample behaves as after reset.
- a_in=0x7FFF with a positive product -> out_sample=0x7FFF. Repeated mu_err=0x7FFF, x=0x7FFF until a weight reaches 0x7FFFFF -> the weight holds at 0x7FFFFF with no wrap.
- CH=3, in_ch=3 -> err_ch pulse, no RUN, no out_valid. clr_valid and in_valid in the same IDLE cycle -> clear taken, sample not taken.
- rst_n asserted mid-RUN at tap 2 -> all outputs 0 immediately, no out_valid; the next accepted sample matches the after-reset result.
